// File: rtl/csr_issue_unit_if.sv
// rtl/csr_issue_unit_if.sv - decode, CSR-file and writeback signals of the CSR issue unit
interface csr_issue_unit_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic            instr_ready;

    logic            csr_valid;
    logic [11:0]     csr_addr;
    logic [2:0]      csr_funct3;
    logic [4:0]      csr_rs1;
    logic [4:0]      csr_rd;
    logic [XLEN-1:0] csr_wdata;
    logic [4:0]      csr_zimm;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_exception;

    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            trap_valid;
    logic [3:0]      trap_cause;
    logic [31:0]     trap_tval;
    logic            retire_inst;

    // master is the issue unit itself; slave is decode plus the CSR file and writeback port
    modport master (
        input  instr_valid, instr, rs1_data, csr_rdata, csr_exception,
        output instr_ready, csr_valid, csr_addr, csr_funct3, csr_rs1, csr_rd,
               csr_wdata, csr_zimm, rd_we, rd_addr, rd_wdata,
               trap_valid, trap_cause, trap_tval, retire_inst
    );

    modport slave (
        output instr_valid, instr, rs1_data, csr_rdata, csr_exception,
        input  instr_ready, csr_valid, csr_addr, csr_funct3, csr_rs1, csr_rd,
               csr_wdata, csr_zimm, rd_we, rd_addr, rd_wdata,
               trap_valid, trap_cause, trap_tval, retire_inst
    );
endinterface

// File: rtl/csr_issue_unit.sv
// rtl/csr_issue_unit.sv - issues one SYSTEM/CSR instruction to the CSR file, then retires or traps
module csr_issue_unit #(
    parameter int XLEN          = 32,
    parameter int CAUSE_ILLEGAL = 2
) (
    input  logic             clk,
    input  logic             rst,
    csr_issue_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [11:0]     addr_q;
    logic [4:0]      rs1_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     tval_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic            exc_q;

    logic            accept;
    logic            legal;
    logic            take_trap;

    assign accept    = bus.instr_valid && (state == IDLE);
    assign legal     = (bus.instr[6:0] == 7'b1110011) &&
                       (bus.instr[14:12] != 3'b000) &&
                       (bus.instr[14:12] != 3'b100);
    assign take_trap = illegal_q || exc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fields are captured for every accepted word, legal or not, so a trap can report tval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            rs1_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            tval_q    <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= bus.instr[31:20];
                rs1_q     <= bus.instr[19:15];
                funct3_q  <= bus.instr[14:12];
                rd_q      <= bus.instr[11:7];
                wdata_q   <= bus.rs1_data;
                tval_q    <= bus.instr;
                illegal_q <= !legal;
                exc_q     <= 1'b0;
                result_q  <= '0;
            end
            if (state == ISSUE) begin
                result_q <= bus.csr_rdata;
                exc_q    <= bus.csr_exception;
            end
        end
    end

    // Strobes decode purely from state so an asynchronous reset drops them at once
    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.csr_valid   = 1'b0;
        bus.rd_we       = 1'b0;
        bus.rd_addr     = '0;
        bus.rd_wdata    = '0;
        bus.trap_valid  = 1'b0;
        bus.trap_cause  = '0;
        bus.trap_tval   = '0;
        bus.retire_inst = 1'b0;

        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = legal ? ISSUE : WB;
                end
            end
            ISSUE: begin
                bus.csr_valid = 1'b1;
                state_nxt     = WB;
            end
            WB: begin
                state_nxt = IDLE;
                if (take_trap) begin
                    bus.trap_valid = 1'b1;
                    bus.trap_cause = 4'(CAUSE_ILLEGAL);
                    bus.trap_tval  = tval_q;
                end else begin
                    bus.retire_inst = 1'b1;
                    bus.rd_we       = (rd_q != 5'd0);
                    bus.rd_addr     = rd_q;
                    bus.rd_wdata    = result_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.csr_addr   = addr_q;
    assign bus.csr_funct3 = funct3_q;
    assign bus.csr_rs1    = rs1_q;
    assign bus.csr_rd     = rd_q;
    assign bus.csr_wdata  = wdata_q;
    assign bus.csr_zimm   = rs1_q;
endmodule

// File: tb/tb_csr_issue_unit.sv
// tb/tb_csr_issue_unit.sv - directed self-checking bench for csr_issue_unit
module tb_csr_issue_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    csr_issue_unit_if #(.XLEN(32)) bus ();

    csr_issue_unit #(.XLEN(32), .CAUSE_ILLEGAL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, midway between active edges
    task automatic offer(input logic [31:0] word, input logic [31:0] rs1v);
        bus.instr_valid = 1'b1;
        bus.instr       = word;
        bus.rs1_data    = rs1v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h want 1", bus.instr_ready); end
        n_cmp++; if (bus.csr_valid !== 1'b0) begin n_err++; $display("FAIL reset_csr_valid: got %0h want 0", bus.csr_valid); end
        n_cmp++; if ({bus.rd_we, bus.trap_valid, bus.retire_inst} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {bus.rd_we, bus.trap_valid, bus.retire_inst}); end
        n_cmp++; if ({bus.csr_addr, bus.csr_wdata, bus.rd_wdata, bus.trap_tval, bus.trap_cause} !== 112'd0) begin n_err++; $display("FAIL reset_fields: got %h want 0", {bus.csr_addr, bus.csr_wdata, bus.rd_wdata, bus.trap_tval, bus.trap_cause}); end
        rst = 1'b0;
    endtask

    task automatic test_read_cycle();
        offer(32'hC00022F3, 32'h5555_AAAA);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_cmp++; if (bus.csr_valid !== 1'b1) begin n_err++; $display("FAIL rdcyc_csr_valid: got %0h want 1", bus.csr_valid); end
        n_cmp++; if ({bus.csr_addr, bus.csr_funct3, bus.csr_rs1, bus.csr_rd} !== {12'hC00, 3'b010, 5'd0, 5'd5}) begin n_err++; $display("FAIL rdcyc_fields: got %h want %h", {bus.csr_addr, bus.csr_funct3, bus.csr_rs1, bus.csr_rd}, {12'hC00, 3'b010, 5'd0, 5'd5}); end
        n_cmp++; if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL rdcyc_ready_issue: got %0h want 0", bus.instr_ready); end
        bus.csr_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.csr_rdata = 32'h0BAD_0BAD;
        n_cmp++; if ({bus.rd_we, bus.retire_inst, bus.trap_valid, bus.csr_valid} !== 4'b1100) begin n_err++; $display("FAIL rdcyc_wb_strobes: got %b want 1100", {bus.rd_we, bus.retire_inst, bus.trap_valid, bus.csr_valid}); end
        n_cmp++; if (bus.rd_addr !== 5'd5) begin n_err++; $display("FAIL rdcyc_rd_addr: got %0d want 5", bus.rd_addr); end
        n_cmp++; if (bus.rd_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdcyc_rd_wdata: got %h want deadbeef", bus.rd_wdata); end
        n_cmp++; if (bus.csr_addr !== 12'hC00) begin n_err++; $display("FAIL rdcyc_addr_hold: got %h want c00", bus.csr_addr); end
        @(negedge clk);
        n_cmp++; if ({bus.instr_ready, bus.retire_inst, bus.rd_we} !== 3'b100) begin n_err++; $display("FAIL rdcyc_idle: got %b want 100", {bus.instr_ready, bus.retire_inst, bus.rd_we}); end
        n_cmp++; if (bus.rd_wdata !== 32'd0) begin n_err++; $display("FAIL rdcyc_wdata_idle: got %h want 0", bus.rd_wdata); end
    endtask

    task automatic test_write_ro_time();
        offer(32'hC0109073, 32'h0000_1234);
        @(negedge clk);
        bus.instr_valid   = 1'b0;
        bus.rs1_data      = 32'hFFFF_FFFF;
        bus.csr_exception = 1'b1;
        n_cmp++; if (bus.csr_wdata !== 32'h0000_1234) begin n_err++; $display("FAIL rotime_wdata: got %h want 1234", bus.csr_wdata); end
        n_cmp++; if ({bus.csr_valid, bus.csr_addr, bus.csr_funct3} !== {1'b1, 12'hC01, 3'b001}) begin n_err++; $display("FAIL rotime_req: got %h want %h", {bus.csr_valid, bus.csr_addr, bus.csr_funct3}, {1'b1, 12'hC01, 3'b001}); end
        @(negedge clk);
        bus.csr_exception = 1'b0;
        n_cmp++; if ({bus.trap_valid, bus.rd_we, bus.retire_inst} !== 3'b100) begin n_err++; $display("FAIL rotime_strobes: got %b want 100", {bus.trap_valid, bus.rd_we, bus.retire_inst}); end
        n_cmp++; if (bus.trap_cause !== 4'd2) begin n_err++; $display("FAIL rotime_cause: got %0d want 2", bus.trap_cause); end
        n_cmp++; if (bus.trap_tval !== 32'hC0109073) begin n_err++; $display("FAIL rotime_tval: got %h want c0109073", bus.trap_tval); end
        @(negedge clk);
        n_cmp++; if ({bus.instr_ready, bus.trap_valid} !== 2'b10) begin n_err++; $display("FAIL rotime_idle: got %b want 10", {bus.instr_ready, bus.trap_valid}); end
    endtask

    // Bad opcode, then the two SYSTEM funct3 values that are not CSR ops
    task automatic test_illegal();
        logic [31:0] words [3];
        words[0] = 32'h0000_0033;
        words[1] = 32'h0000_0073;
        words[2] = 32'h0000_4073;
        for (int i = 0; i < 3; i++) begin
            offer(words[i], 32'h0);
            @(negedge clk);
            bus.instr_valid = 1'b0;
            n_cmp++; if ({bus.csr_valid, bus.trap_valid, bus.instr_ready, bus.retire_inst} !== 4'b0100) begin n_err++; $display("FAIL illegal%0d_wb: got %b want 0100", i, {bus.csr_valid, bus.trap_valid, bus.instr_ready, bus.retire_inst}); end
            n_cmp++; if (bus.trap_tval !== words[i]) begin n_err++; $display("FAIL illegal%0d_tval: got %h want %h", i, bus.trap_tval, words[i]); end
            @(negedge clk);
            n_cmp++; if ({bus.instr_ready, bus.csr_valid, bus.trap_valid} !== 3'b100) begin n_err++; $display("FAIL illegal%0d_idle: got %b want 100", i, {bus.instr_ready, bus.csr_valid, bus.trap_valid}); end
        end
    endtask

    task automatic test_instreth();
        offer(32'hC82063F3, 32'hCAFE_F00D);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.csr_rdata   = 32'h0000_0012;
        n_cmp++; if ({bus.csr_valid, bus.csr_zimm, bus.csr_addr, bus.csr_funct3} !== {1'b1, 5'd0, 12'hC82, 3'b110}) begin n_err++; $display("FAIL insth_req: got %h want %h", {bus.csr_valid, bus.csr_zimm, bus.csr_addr, bus.csr_funct3}, {1'b1, 5'd0, 12'hC82, 3'b110}); end
        @(negedge clk);
        n_cmp++; if ({bus.rd_we, bus.rd_addr, bus.rd_wdata} !== {1'b1, 5'd7, 32'h0000_0012}) begin n_err++; $display("FAIL insth_wb: got %h want %h", {bus.rd_we, bus.rd_addr, bus.rd_wdata}, {1'b1, 5'd7, 32'h0000_0012}); end
        @(negedge clk);
    endtask

    // Second word writes x0: it must retire without a register write
    task automatic test_back_to_back();
        int ret_cnt;
        int ret_at [2];
        ret_cnt = 0;
        ret_at[0] = -1;
        ret_at[1] = -1;
        offer(32'hC00022F3, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.instr     = 32'hC0002073;
                bus.csr_rdata = 32'h0000_00A1;
            end
            if (c == 3) begin
                n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c3: got %0h want 1", bus.instr_ready); end
            end
            if (c == 4) begin
                bus.instr_valid = 1'b0;
                n_cmp++; if ({bus.csr_valid, bus.csr_rd, bus.csr_addr} !== {1'b1, 5'd0, 12'hC00}) begin n_err++; $display("FAIL b2b_second_issue: got %h want %h", {bus.csr_valid, bus.csr_rd, bus.csr_addr}, {1'b1, 5'd0, 12'hC00}); end
            end
            if (c == 5) begin
                n_cmp++; if (bus.rd_we !== 1'b0) begin n_err++; $display("FAIL b2b_x0_we: got %0h want 0", bus.rd_we); end
            end
            if (bus.retire_inst === 1'b1) begin
                if (ret_cnt < 2) ret_at[ret_cnt] = c;
                ret_cnt++;
            end
        end
        n_cmp++; if (ret_cnt !== 2) begin n_err++; $display("FAIL b2b_retire_count: got %0d want 2", ret_cnt); end
        n_cmp++; if (ret_at[0] !== 2 || ret_at[1] !== 5) begin n_err++; $display("FAIL b2b_retire_cycles: got %0d,%0d want 2,5", ret_at[0], ret_at[1]); end
    endtask

    task automatic test_reset_issue();
        int bad;
        offer(32'hC00022F3, 32'h0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        n_cmp++; if (bus.csr_valid !== 1'b1) begin n_err++; $display("FAIL rstiss_pre_valid: got %0h want 1", bus.csr_valid); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.csr_valid, bus.instr_ready} !== 2'b01) begin n_err++; $display("FAIL rstiss_async_drop: got %b want 01", {bus.csr_valid, bus.instr_ready}); end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if ({bus.rd_we, bus.trap_valid, bus.retire_inst, bus.csr_valid} !== 4'b0000 || bus.instr_ready !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstiss_quiet_in_reset: got %0d bad cycles want 0", bad); end
        offer(32'hC00022F3, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.csr_rdata   = 32'hA5A5_0001;
        n_cmp++; if (bus.csr_valid !== 1'b1) begin n_err++; $display("FAIL rstiss_first_accept: got %0h want 1", bus.csr_valid); end
        @(negedge clk);
        n_cmp++; if ({bus.retire_inst, bus.rd_we, bus.rd_wdata} !== {1'b1, 1'b1, 32'hA5A5_0001}) begin n_err++; $display("FAIL rstiss_after_release: got %h want %h", {bus.retire_inst, bus.rd_we, bus.rd_wdata}, {1'b1, 1'b1, 32'hA5A5_0001}); end
        @(negedge clk);
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL rstiss_ready_end: got %0h want 1", bus.instr_ready); end
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        rst               = 1'b1;
        bus.instr_valid   = 1'b0;
        bus.instr         = 32'h0;
        bus.rs1_data      = 32'h0;
        bus.csr_rdata     = 32'h0;
        bus.csr_exception = 1'b0;
        test_reset();
        test_read_cycle();
        test_write_ro_time();
        test_illegal();
        test_instreth();
        test_back_to_back();
        test_reset_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
